// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder built from a chain of 1-bit
// full-adder cells. S/Cout are purely combinational; S_r/Cout_r are copies
// registered on clk and cleared asynchronously while rst_n is low.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic [WIDTH-1:0] S_r,
  output logic             Cout_r
);

  // Carry chain: w_carry[0] is the carry-in, w_carry[WIDTH] the carry-out.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  assign w_carry[0] = Cin;

  // One full-adder cell per bit. The carry is written as a plain
  // majority function so X/Z on any input propagates without masking.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign w_sum[gi]     = A[gi] ^ B[gi] ^ w_carry[gi];
      assign w_carry[gi+1] = (A[gi] & B[gi]) |
                             (A[gi] & w_carry[gi]) |
                             (B[gi] & w_carry[gi]);
    end
  endgenerate

  assign S    = w_sum;
  assign Cout = w_carry[WIDTH];

  // Capture the combinational result each rising edge; clear at once on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_carry[WIDTH];
    end
  end

  assign S_r    = r_sum;
  assign Cout_r = r_cout;

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: scoreboard bench for full_adder at WIDTH=1 and WIDTH=4.
// Stimulus pushes hand-computed expectations into a queue; a monitor
// drains the queue on every falling clock edge and compares.
module tb_full_adder;

  logic       clk;
  logic       rst_n;

  logic [0:0] a1, b1, s1, sr1;
  logic       cin1, cout1, coutr1;

  logic [3:0] a4, b4, s4, sr4;
  logic       cin4, cout4, coutr4;

  typedef struct {
    string    name;
    int       sel;     // 0: comb W1, 1: comb W4, 2: reg W1, 3: reg W4
    logic [3:0] exp_s;
    logic     exp_c;
  } item_t;

  item_t sb_q[$];

  int compared;
  int mismatched;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1),
    .S(s1), .Cout(cout1), .S_r(sr1), .Cout_r(coutr1)
  );

  full_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4),
    .S(s4), .Cout(cout4), .S_r(sr4), .Cout_r(coutr4)
  );

  // 10 ns clock: rising edges at 5, 15, ...; falling edges at 10, 20, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Gray-code walk of {A,B,Cin}, one input changing per step.
  logic [2:0] w1_vec [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                             3'b110, 3'b111, 3'b101, 3'b100};
  // Hand-computed {Cout,S} for each walk entry.
  logic [1:0] w1_exp [8] = '{2'b00, 2'b01, 2'b10, 2'b01,
                             2'b10, 2'b11, 2'b10, 2'b01};

  logic [3:0] v4_a   [9] = '{4'hF, 4'hF, 4'h0, 4'h5, 4'h5, 4'h7, 4'h9, 4'h3, 4'h8};
  logic [3:0] v4_b   [9] = '{4'h0, 4'hF, 4'h0, 4'hA, 4'hA, 4'h8, 4'h6, 4'h4, 4'h8};
  logic       v4_cin [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  // Hand-computed {Cout,S}.
  logic [4:0] v4_exp [9] = '{5'h10, 5'h1F, 5'h00, 5'h0F, 5'h10, 5'h0F, 5'h10, 5'h07, 5'h10};

  task automatic push(input string name, input int sel,
                      input logic [3:0] s, input logic c);
    item_t it;
    it.name  = name;
    it.sel   = sel;
    it.exp_s = s;
    it.exp_c = c;
    sb_q.push_back(it);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every pending expectation against the DUT outputs.
  initial begin
    item_t      it;
    logic [3:0] got_s;
    logic       got_c;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        case (it.sel)
          0:       begin got_s = {3'b000, s1};  got_c = cout1;  end
          1:       begin got_s = s4;            got_c = cout4;  end
          2:       begin got_s = {3'b000, sr1}; got_c = coutr1; end
          default: begin got_s = sr4;           got_c = coutr4; end
        endcase
        compared++;
        if (got_s !== it.exp_s || got_c !== it.exp_c) begin
          mismatched++;
          $display("FAIL %s t=%0t: got S=%h Cout=%b, expected S=%h Cout=%b",
                   it.name, $time, got_s, got_c, it.exp_s, it.exp_c);
        end else begin
          $display("ok   %s t=%0t: S=%h Cout=%b", it.name, $time, got_s, got_c);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic [1:0] prev1;
    logic [4:0] prev4;
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    #1;
    push("reset_comb_w1", 0, 4'h0, 1'b0);
    push("reset_comb_w4", 1, 4'h0, 1'b0);
    push("reset_reg_w1",  2, 4'h0, 1'b0);
    push("reset_reg_w4",  3, 4'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Full WIDTH=1 truth table, one input change every 50 ns.
    prev1 = 2'b00;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = w1_vec[i];
      push($sformatf("w1_comb_%03b", w1_vec[i]), 0, {3'b000, w1_exp[i][0]}, w1_exp[i][1]);
      push($sformatf("w1_reg_hold_%03b", w1_vec[i]), 2, {3'b000, prev1[0]}, prev1[1]);
      step();
      push($sformatf("w1_reg_%03b", w1_vec[i]), 2, {3'b000, w1_exp[i][0]}, w1_exp[i][1]);
      prev1 = w1_exp[i];
      repeat (4) step();
    end

    // Registered path: 1+1+0 -> S=0, Cout=1, registered one edge later.
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    push("w1_comb_110b", 0, 4'h0, 1'b1);
    push("w1_reg_before_edge", 2, {3'b000, prev1[0]}, prev1[1]);
    step();
    push("w1_reg_after_edge", 2, 4'h0, 1'b1);

    // WIDTH=4 directed vectors, including full-chain carry propagation.
    prev4 = 5'h00;
    for (int i = 0; i < 9; i++) begin
      a4 = v4_a[i]; b4 = v4_b[i]; cin4 = v4_cin[i];
      push($sformatf("w4_comb_%h_%h_%b", v4_a[i], v4_b[i], v4_cin[i]), 1, v4_exp[i][3:0], v4_exp[i][4]);
      push($sformatf("w4_reg_hold_%0d", i), 3, prev4[3:0], prev4[4]);
      step();
      push($sformatf("w4_reg_%h_%h_%b", v4_a[i], v4_b[i], v4_cin[i]), 3, v4_exp[i][3:0], v4_exp[i][4]);
      prev4 = v4_exp[i];
      step();
    end

    // Async reset between edges while Cout_r is 1 on both instances.
    #1;
    rst_n = 1'b0;
    #1;
    push("async_rst_reg_w1",  2, 4'h0, 1'b0);
    push("async_rst_reg_w4",  3, 4'h0, 1'b0);
    push("async_rst_comb_w1", 0, 4'h0, 1'b1);
    push("async_rst_comb_w4", 1, 4'h0, 1'b1);
    @(negedge clk);
    #1;
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    a4 = 4'h3; b4 = 4'h4; cin4 = 1'b0;
    push("rst_track_comb_w1", 0, 4'h1, 1'b0);
    push("rst_track_comb_w4", 1, 4'h7, 1'b0);
    push("rst_track_reg_w1",  2, 4'h0, 1'b0);
    step();
    push("rst_held_reg_w1", 2, 4'h0, 1'b0);
    push("rst_held_reg_w4", 3, 4'h0, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    push("rst_release_no_edge_w1", 2, 4'h0, 1'b0);
    step();
    push("rst_reload_reg_w1", 2, 4'h1, 1'b0);
    push("rst_reload_reg_w4", 3, 4'h7, 1'b0);

    repeat (2) step();
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at t=%0t, expected finish earlier", $time);
    $fatal(1);
  end

endmodule
